// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller: default geometry,
// FSM state encoding and the fill pattern used at start-up.
package ram_access_ctrl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Word written at address k during a fill; callers truncate to their data width.
    function automatic logic [31:0] fill_pattern(input logic [31:0] k);
        return k << 32'd1;
    endfunction

endpackage

// File: rtl/ram_access_ctrl.sv
// Front-end controller for a single-port RAM: fills the array after reset,
// then serves single-word read/write requests with a valid/ready read response.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int INIT_FILL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              init_done,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam state_t ST_RESET        = (INIT_FILL != 0) ? ST_FILL : ST_IDLE;
    localparam logic   INIT_DONE_RESET = (INIT_FILL == 0);

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_s;
    logic              req_ready_s;
    logic              rd_valid_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              init_done_s;
    logic              ram_cs_s;
    logic              ram_wr_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_din_s;

    // State, fill counter and every output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RESET;
            cnt_r     <= '0;
            req_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            init_done <= INIT_DONE_RESET;
            ram_cs    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            req_ready <= req_ready_s;
            rd_valid  <= rd_valid_s;
            rd_data   <= rd_data_s;
            init_done <= init_done_s;
            ram_cs    <= ram_cs_s;
            ram_wr    <= ram_wr_s;
            ram_addr  <= ram_addr_s;
            ram_din   <= ram_din_s;
        end
    end

    // Next state and the output values that go with it; outputs hold by default.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        req_ready_s = req_ready;
        rd_valid_s  = rd_valid;
        rd_data_s   = rd_data;
        init_done_s = init_done;
        ram_cs_s    = ram_cs;
        ram_wr_s    = ram_wr;
        ram_addr_s  = ram_addr;
        ram_din_s   = ram_din;

        case (state_r)
            ST_FILL: begin
                ram_cs_s    = 1'b1;
                ram_wr_s    = 1'b1;
                ram_addr_s  = cnt_r;
                ram_din_s   = DATA_W'(fill_pattern(32'(cnt_r)));
                cnt_s       = cnt_r + ADDR_W'(1);
                req_ready_s = 1'b0;
                init_done_s = 1'b0;
                // The last word is being written this edge; strobes drop on the next one.
                if (cnt_r == {ADDR_W{1'b1}}) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FILL;
                end
            end

            ST_IDLE: begin
                ram_cs_s    = 1'b0;
                ram_wr_s    = 1'b0;
                req_ready_s = 1'b1;
                init_done_s = 1'b1;
                // A pending request always beats a simultaneous fill_req.
                if (req_valid) begin
                    if (req_ready) begin
                        state_s     = ST_ACCESS;
                        req_ready_s = 1'b0;
                        ram_cs_s    = 1'b1;
                        ram_wr_s    = req_we;
                        ram_addr_s  = req_addr;
                        ram_din_s   = req_wdata;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (fill_req) begin
                    state_s     = ST_FILL;
                    cnt_s       = '0;
                    req_ready_s = 1'b0;
                    init_done_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                ram_cs_s = 1'b0;
                ram_wr_s = 1'b0;
                if (ram_wr) begin
                    state_s     = ST_IDLE;
                    req_ready_s = 1'b1;
                end else begin
                    state_s     = ST_RESP;
                    rd_data_s   = ram_dout;
                    rd_valid_s  = 1'b1;
                    req_ready_s = 1'b0;
                end
            end

            ST_RESP: begin
                ram_cs_s = 1'b0;
                ram_wr_s = 1'b0;
                if (rd_ready) begin
                    state_s     = ST_IDLE;
                    rd_valid_s  = 1'b0;
                    req_ready_s = 1'b1;
                end else begin
                    state_s = ST_RESP;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                ram_cs_s    = 1'b0;
                ram_wr_s    = 1'b0;
                rd_valid_s  = 1'b0;
                req_ready_s = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Synchronous front-end controller for the 1K x 8 single-port RAM with separate data-in/data-out buses and `wr`/`cs` strobes.
- Owns every RAM strobe and bus: at reset it fills the array with a deterministic pattern, then serves single-word read/write requests from an upstream valid/ready port.
- Returns read data on a valid/ready response port.
- Replaces the ad-hoc stimulus loops that today drive the RAM directly.

Parameters:
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, RAM word width.
- INIT_FILL, 1, 1 = run a fill sequence automatically after reset; 0 = come out of reset in IDLE with init_done=1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fill_req  in  1  single-cycle pulse; starts a fill sequence. Honoured only in IDLE.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rd_valid  out  1  read response valid.
- rd_ready  in  1  downstream accepts the response.
- rd_data  out  DATA_W  read data.
- init_done  out  1  fill complete; sticky until reset or the next fill.
- ram_cs  out  1  RAM chip select.
- ram_wr  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data; combinational from ram_addr while ram_cs=1 and ram_wr=0.

Behaviour:
- Outputs: all outputs are registered.
- Reset values: ram_cs=0, ram_wr=0, ram_addr=0, ram_din=0, req_ready=0, rd_valid=0, rd_data=0, init_done=0 (init_done=1 when INIT_FILL=0). Fill counter=0. State=FILL if INIT_FILL=1, else IDLE.
- States: FILL, IDLE, ACCESS, RESP.
- FILL:
  - Each cycle: ram_cs=1, ram_wr=1, ram_addr=cnt, ram_din=(2*cnt) mod 2**DATA_W, i.e. {cnt[DATA_W-2:0],1'b0}.
  - cnt increments each cycle; req_ready=0.
  - After the write to address DEPTH-1: cnt wraps to 0, state -> IDLE, init_done=1, ram_cs=0, ram_wr=0.
  - The fill takes exactly DEPTH cycles.
  - fill_req is ignored while already in FILL.
- IDLE:
  - req_ready=1, ram_cs=0, ram_wr=0.
  - If req_valid=1: latch req_we/req_addr/req_wdata, drop req_ready, go to ACCESS.
  - Else if fill_req=1: clear init_done, go to FILL.
  - If req_valid and fill_req are both high in the same cycle, the request wins and fill_req is dropped.
- ACCESS (exactly one cycle):
  - ram_cs=1, ram_wr=latched we, ram_addr/ram_din from the latched values.
  - Write: next state is IDLE; no response is generated.
  - Read: ram_dout is sampled into rd_data at the end of this cycle, rd_valid=1 next cycle, state -> RESP.
- RESP:
  - ram_cs=0.
  - rd_valid and rd_data hold stable until rd_ready=1. On that handshake cycle rd_valid deasserts on the next edge and the state returns to IDLE.
  - No new request is accepted while in RESP.
- Throughput:
  - Write: 2 cycles per request (IDLE accept + ACCESS).
  - Read: 3 cycles minimum, from accept to rd_valid to IDLE.
- Timing relations:
  - ram_wr is never 1 while ram_cs is 0.
  - ram_addr and ram_din are stable for the whole cycle in which ram_wr=1.
- Reset mid-operation:
  - rst_n low forces all outputs to their reset values immediately. This aborts any fill or access; the interrupted RAM write has an undefined result.
  - With INIT_FILL=1, the fill restarts from address 0 after reset release.
- Address and width rules:
  - Addresses wrap naturally at DEPTH; the fill counter is ADDR_W bits wide.
  - No overflow detection is required.

Decomposition:
- Shared package: state encoding constants (FILL, IDLE, ACCESS, RESP), the default ADDR_W/DATA_W values, and the fill-pattern function (2*k mod 2**DATA_W), so the bench can compute the same expected values.
- No sub-module is needed. The fill counter stays inline.
- The RAM model is instantiated only in the bench.

Test Plan:
- Reset release with INIT_FILL=1 -> ram_cs=ram_wr=1 for exactly 1024 cycles with addr 0..1023 and din 0,2,4,…,254,0,…; init_done rises in cycle 1024; req_ready=0 throughout the fill.
- After the fill, read addr 5, then addr 1023 -> rd_data=10 (0x0A), then 254 (0xFE); each rd_valid appears 2 cycles after req accept.
- Write addr 300 data 0xA5, then read addr 300 -> rd_data=0xA5; neighbouring addr 301 still reads 90 (602 mod 256).
- Read addr 7 with rd_ready held low for 5 cycles -> rd_valid and rd_data=14 stay stable; req_ready=0 until one cycle after rd_ready=1.
- Drop rst_n at fill cycle 500 -> all RAM strobes go to 0 immediately; after release the fill restarts at addr 0 and completes after 1024 cycles.
- In IDLE, assert req_valid (read addr 0) and fill_req in the same cycle -> read is served (rd_data=0), no fill starts, init_done stays 1.
- A later lone fill_req pulse -> init_done=0 and a full 1024-cycle refill runs.
